// File: rtl/rv_pkg.sv
// Shared register-file types: data width, register count and the writeback request payload.
package rv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t        addr;
    logic [XLEN-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Buffer for secondary writeback results, with a per-slot address view for hazard tracking.
module wb_fifo
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  wb_req_t                 push_req,
  input  logic                    pop,
  output logic                    full,
  output logic                    empty,
  output wb_req_t                 head,
  output logic [DEPTH*REG_AW-1:0] entry_addrs
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_req_t            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset because occupancy gates every use.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_req;
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Report each occupied slot's address; empty slots read as x0, which never marks a hazard.
  always_comb begin
    entry_addrs = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] offs;
      offs = PTR_W'(i) - rd_ptr;
      if ({1'b0, offs} < count) entry_addrs[i*REG_AW +: REG_AW] = mem[i].addr;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single owner of the register-file write port: primary results win, secondary results
// are buffered, and a starvation counter forces a secondary slot after repeated primary wins.
module regfile_write_arbiter
  import rv_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pri_valid,
  input  logic [4:0]       pri_addr,
  input  logic [XLEN-1:0]  pri_data,
  output logic             pri_stall,
  input  logic             sec_valid,
  output logic             sec_ready,
  input  logic [4:0]       sec_addr,
  input  logic [XLEN-1:0]  sec_data,
  output logic             we,
  output logic [4:0]       wa,
  output logic [XLEN-1:0]  wd,
  output logic [NREGS-1:0] pending_mask,
  output logic             waw_err
);

  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

  logic                         fifo_full;
  logic                         fifo_empty;
  logic                         fifo_push;
  logic                         fifo_pop;
  wb_req_t                      fifo_head;
  logic [FIFO_DEPTH*REG_AW-1:0] entry_addrs;
  logic [SC_W-1:0]              starve_cnt;
  logic                         pri_issue;
  logic                         bypass;
  logic                         sec_accept;
  logic                         nxt_we;
  reg_addr_t                    nxt_wa;
  logic [XLEN-1:0]              nxt_wd;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (fifo_push),
    .push_req    ('{addr: sec_addr, data: sec_data}),
    .pop         (fifo_pop),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .head        (fifo_head),
    .entry_addrs (entry_addrs)
  );

  assign pri_stall  = (starve_cnt == SC_W'(STARVE_LIMIT)) && !fifo_empty;
  assign sec_ready  = !fifo_full;
  assign sec_accept = sec_valid && sec_ready;

  // Port selection: forced slot, primary, FIFO head, secondary bypass, idle.
  always_comb begin
    fifo_pop  = 1'b0;
    pri_issue = 1'b0;
    bypass    = 1'b0;
    nxt_we    = 1'b0;
    nxt_wa    = '0;
    nxt_wd    = '0;
    if (pri_stall) begin
      fifo_pop = 1'b1;
      nxt_we   = 1'b1;
      nxt_wa   = fifo_head.addr;
      nxt_wd   = fifo_head.data;
    end else if (pri_valid) begin
      pri_issue = 1'b1;
      if (pri_addr != '0) begin
        nxt_we = 1'b1;
        nxt_wa = pri_addr;
        nxt_wd = pri_data;
      end
    end else if (!fifo_empty) begin
      fifo_pop = 1'b1;
      nxt_we   = 1'b1;
      nxt_wa   = fifo_head.addr;
      nxt_wd   = fifo_head.data;
    end else if (sec_accept && sec_addr != '0) begin
      bypass = 1'b1;
      nxt_we = 1'b1;
      nxt_wa = sec_addr;
      nxt_wd = sec_data;
    end
    fifo_push = sec_accept && (sec_addr != '0) && !bypass;
  end

  // Count primary wins that leave buffered secondary results waiting.
  always_ff @(posedge clk) begin
    if (rst || fifo_pop || fifo_empty) starve_cnt <= '0;
    else if (pri_issue)                starve_cnt <= starve_cnt + SC_W'(1);
  end

  // Registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      we <= 1'b0;
      wa <= '0;
      wd <= '0;
    end else begin
      we <= nxt_we;
      wa <= nxt_wa;
      wd <= nxt_wd;
    end
  end

  // Registers with a write queued or on the port; x0 is never pending.
  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      pending_mask[entry_addrs[i*REG_AW +: REG_AW]] = 1'b1;
    end
    if (we) pending_mask[wa] = 1'b1;
    pending_mask[0] = 1'b0;
  end

  // Sticky flag for a primary write to a register that already has a write outstanding.
  always_ff @(posedge clk) begin
    if (rst)                                                   waw_err <= 1'b0;
    else if (pri_valid && pri_addr != '0 && pending_mask[pri_addr]) waw_err <= 1'b1;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench with a queue-based reference model and a port-write scoreboard.
module tb_regfile_write_arbiter;
  import rv_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pri_valid;
  reg_addr_t   pri_addr;
  logic [31:0] pri_data;
  logic        pri_stall;
  logic        sec_valid;
  logic        sec_ready;
  reg_addr_t   sec_addr;
  logic [31:0] sec_data;
  logic        we;
  reg_addr_t   wa;
  logic [31:0] wd;
  logic [31:0] pending_mask;
  logic        waw_err;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pri_valid(pri_valid), .pri_addr(pri_addr), .pri_data(pri_data), .pri_stall(pri_stall),
    .sec_valid(sec_valid), .sec_ready(sec_ready), .sec_addr(sec_addr), .sec_data(sec_data),
    .we(we), .wa(wa), .wd(wd), .pending_mask(pending_mask), .waw_err(waw_err)
  );

  // Reference model state: buffered secondary writes, starvation count, expected port contents.
  wb_req_t     mq[$];
  int unsigned m_starve = 0;
  bit          m_we = 1'b0;
  reg_addr_t   m_wa = '0;
  logic [31:0] m_wd = '0;
  bit          m_waw = 1'b0;
  wb_req_t     exp_q[$];
  bit          done = 1'b0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] model_mask();
    logic [31:0] mk;
    mk = '0;
    foreach (mq[i]) mk[mq[i].addr] = 1'b1;
    if (m_we) mk[m_wa] = 1'b1;
    mk[0] = 1'b0;
    return mk;
  endfunction

  function automatic bit model_stall();
    return (m_starve == LIMIT) && (mq.size() != 0);
  endfunction

  function automatic bit model_ready();
    return mq.size() < DEPTH;
  endfunction

  // Advance the model by one clock given the inputs presented this cycle.
  task automatic model_step(input bit r, input bit pv, input reg_addr_t pa, input logic [31:0] pd,
                            input bit sv, input reg_addr_t sa, input logic [31:0] sd);
    bit stall, ready, empty, popped, issued, byp, accept, nwe;
    reg_addr_t nwa;
    logic [31:0] nwd, mask;
    wb_req_t h;
    if (r) begin
      mq.delete();
      m_starve = 0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_waw = 1'b0;
      return;
    end
    stall = model_stall(); ready = model_ready(); mask = model_mask();
    empty = (mq.size() == 0);
    if (pv && pa != 0 && mask[pa]) m_waw = 1'b1;
    popped = 1'b0; issued = 1'b0; byp = 1'b0; nwe = 1'b0; nwa = '0; nwd = '0;
    accept = sv && ready;
    if (stall) begin
      h = mq.pop_front(); popped = 1'b1; nwe = 1'b1; nwa = h.addr; nwd = h.data;
    end else if (pv) begin
      issued = 1'b1;
      if (pa != 0) begin nwe = 1'b1; nwa = pa; nwd = pd; end
    end else if (!empty) begin
      h = mq.pop_front(); popped = 1'b1; nwe = 1'b1; nwa = h.addr; nwd = h.data;
    end else if (accept && sa != 0) begin
      byp = 1'b1; nwe = 1'b1; nwa = sa; nwd = sd;
    end
    if (accept && sa != 0 && !byp) mq.push_back('{addr: sa, data: sd});
    if (popped || empty) m_starve = 0;
    else if (issued)     m_starve++;
    m_we = nwe; m_wa = nwa; m_wd = nwd;
    if (nwe) exp_q.push_back('{addr: nwa, data: nwd});
  endtask

  task automatic drive(input bit r, input bit pv, input reg_addr_t pa, input logic [31:0] pd,
                       input bit sv, input reg_addr_t sa, input logic [31:0] sd);
    @(negedge clk);
    rst = r; pri_valid = pv; pri_addr = pa; pri_data = pd;
    sec_valid = sv; sec_addr = sa; sec_data = sd;
    model_step(r, pv, pa, pd, sv, sa, sd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare state-derived outputs each cycle and pop the scoreboard on every write.
  always @(posedge clk) begin
    wb_req_t e;
    #1;
    check("we", 32'(we), 32'(m_we));
    check("pri_stall", 32'(pri_stall), 32'(model_stall()));
    check("sec_ready", 32'(sec_ready), 32'(model_ready()));
    check("pending_mask", pending_mask, model_mask());
    check("waw_err", 32'(waw_err), 32'(m_waw));
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: wa %0d wd %h, none expected at %0t", wa, wd, $time);
      end else begin
        e = exp_q.pop_front();
        check("wa", 32'(wa), 32'(e.addr));
        check("wd", wd, e.data);
      end
    end
    if (done) begin
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    bit cur_pv, cur_sv, r;
    reg_addr_t cur_pa, cur_sa;
    logic [31:0] cur_pd, cur_sd;
    int k, pct;

    // Reset held two cycles while the primary is asserted.
    rst = 1'b1; pri_valid = 1'b1; pri_addr = 5'd9; pri_data = 32'h1234_5678;
    sec_valid = 1'b0; sec_addr = '0; sec_data = '0;
    model_step(1'b1, 1'b1, 5'd9, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
    drive(1'b1, 1'b1, 5'd9, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
    idle(2);

    // Primary only.
    drive(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    idle(2);

    // Same-cycle collision: secondary goes through the FIFO.
    drive(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    idle(3);

    // Fill the FIFO under sustained primary traffic until a forced slot appears.
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (!model_stall()) k++;
      drive(1'b0, 1'b1, 5'(10 + (k % 5)), 32'hA000_0000 + 32'(k),
            i < 4, 5'(3 + i), 32'hB000_0000 + 32'(i));
    end
    idle(8);

    // x0 secondary writes: bypass path, then alongside a non-empty FIFO.
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    drive(1'b0, 1'b1, 5'd12, 32'h12, 1'b1, 5'd9, 32'h99);
    drive(1'b0, 1'b1, 5'd13, 32'h13, 1'b1, 5'd0, 32'hFFFF_FFFF);
    idle(4);

    // WAW on a queued register, then reset before it drains.
    drive(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'h77);
    drive(1'b0, 1'b1, 5'd7, 32'h70, 1'b0, 5'd0, 32'd0);
    drive(1'b0, 1'b1, 5'd8, 32'h80, 1'b0, 5'd0, 32'd0);
    drive(1'b0, 1'b1, 5'd9, 32'h90, 1'b0, 5'd0, 32'd0);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle(4);

    // Random traffic alternating light and heavy primary load.
    cur_pv = 1'b0; cur_sv = 1'b0; cur_pa = 5'd1; cur_sa = 5'd1; cur_pd = '0; cur_sd = '0;
    for (int c = 0; c < 4000; c++) begin
      pct = ((c / 200) % 2 == 1) ? 95 : 45;
      if (!(cur_pv && model_stall())) begin
        cur_pv = ($urandom_range(0, 99) < pct);
        cur_pa = 5'($urandom_range(1, 31));
        cur_pd = $urandom;
      end
      if (!(cur_sv && !model_ready())) begin
        cur_sv = 1'($urandom_range(0, 1));
        cur_sa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        cur_sd = $urandom;
      end
      r = ($urandom_range(0, 299) == 0);
      drive(r, cur_pv, cur_pa, cur_pd, cur_sv, cur_sa, cur_sd);
    end
    idle(12);
    done = 1'b1;
  end

endmodule
